div32_seq: RTL and testbench
============================

DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 The block SHALL have parameter SIGNED, default 1, where 1 selects two's-complement division and 0 selects unsigned division.
REQ-002 The block SHALL have port i_clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port i_dividend, input, 32 bits: dividend, captured on the accepted start edge.
REQ-006 The block SHALL have port i_divisor, input, 32 bits: divisor, captured on the accepted start edge.
REQ-007 The block SHALL have port o_quotient, output, 32 bits: quotient result.
REQ-008 The block SHALL have port o_remainder, output, 32 bits: remainder result.
REQ-009 The block SHALL have port o_busy, output, 1 bit: high while a division is in progress.
REQ-010 The block SHALL have port o_done, output, 1 bit: one-cycle pulse; results valid.
REQ-011 The block SHALL have port o_div_by_zero, output, 1 bit: last completed division had a zero divisor.

Function
REQ-012 The block SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-013 IDLE SHALL transition to CALC when i_start=1 and i_divisor!=0, and to DONE when i_start=1 and i_divisor==0.
REQ-014 On the accepted start edge, the block SHALL capture the operand magnitudes, the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign); signs are forced to 0 when SIGNED=0.
REQ-015 CALC SHALL run exactly 32 cycles of restoring shift-subtract on the 32-bit magnitudes, one quotient bit per cycle, using an internal 6-bit iteration counter; it then transitions to FIX.
REQ-016 FIX SHALL negate the quotient and remainder magnitudes per the captured signs, load o_quotient/o_remainder, and transition to DONE.
REQ-017 DONE SHALL assert o_done for exactly one cycle and return to IDLE.
REQ-018 o_busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-019 For a nonzero divisor, o_done SHALL be high in the 34th cycle after the start edge (start edge = edge 0; o_done rises at edge 34).
REQ-020 Results SHALL truncate toward zero, the remainder SHALL take the dividend's sign, and quotient*divisor+remainder SHALL equal the dividend modulo 2^32.
REQ-021 Overflow case 0x80000000 / 0xFFFFFFFF (SIGNED=1) SHALL yield quotient 0x80000000 and remainder 0, with no error flag.
REQ-022 Division by zero SHALL yield quotient 0xFFFFFFFF, remainder = i_dividend and o_div_by_zero=1, with o_done high at edge 1 after the start edge.
REQ-023 o_div_by_zero SHALL be cleared on the next accepted start with a nonzero divisor.
REQ-024 i_start while o_busy=1 or in DONE SHALL be ignored, with no effect on the operation in flight or the captured operands.
REQ-025 o_quotient, o_remainder and o_div_by_zero SHALL hold their values from the load in FIX or DONE until the next completed operation.
REQ-026 Operand changes after the start edge SHALL have no effect on the result.

Reset
REQ-027 i_rst_n=0 SHALL immediately, without waiting for a clock, force the state to IDLE and clear o_quotient, o_remainder, o_busy, o_done, o_div_by_zero, the counter and all internal registers to 0.
REQ-028 Reset asserted mid-CALC or mid-FIX SHALL abort the operation; no o_done is produced for it.
REQ-029 After i_rst_n deasserts, the block SHALL accept i_start on the first rising edge.

Verification
REQ-030 SIGNED=1, 100 / 7 -> o_done at edge 34; quotient 0x0000000E, remainder 0x00000002, o_div_by_zero=0.
REQ-031 SIGNED=1, -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; and 100 / -7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
REQ-032 SIGNED=1, 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; SIGNED=0, 0xFFFFFFFF / 2 -> quotient 0x7FFFFFFF, remainder 1.
REQ-033 5 / 0 -> o_done at edge 1, quotient 0xFFFFFFFF, remainder 5, o_div_by_zero=1; a following 9 / 3 -> quotient 3, o_div_by_zero=0.
REQ-034 i_start pulsed with new operands 5 cycles into CALC -> first result unchanged, o_done pulses once, o_busy timing unchanged.
REQ-035 i_rst_n low asynchronously at cycle 10 of CALC -> all outputs 0 before the next edge, no o_done; a new 100 / 7 issued after release completes correctly.

Source files
------------

// File: rtl/div32_seq.sv
// Sequential 32-bit divider: restoring shift-subtract over 32 cycles, then sign fix-up.
// SIGNED=1 gives truncating two's-complement division; SIGNED=0 gives unsigned division.
module div32_seq #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div_by_zero
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        dz_pend_q;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        fits;

    always_comb begin
        a_neg  = SIGNED && i_dividend[31];
        b_neg  = SIGNED && i_divisor[31];
        a_mag  = a_neg ? (32'd0 - i_dividend) : i_dividend;
        b_mag  = b_neg ? (32'd0 - i_divisor) : i_divisor;
        // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder.
        rem_sh = {rem_q, quo_q[31]};
        diff   = rem_sh - {1'b0, dvs_q};
        fits   = !diff[32];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= 6'd0;
            quo_q         <= 32'd0;
            rem_q         <= 32'd0;
            dvs_q         <= 32'd0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dz_pend_q     <= 1'b0;
            o_quotient    <= 32'd0;
            o_remainder   <= 32'd0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_done <= (state_q == StDone);
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        cnt_q   <= 6'd0;
                        q_neg_q <= a_neg ^ b_neg;
                        r_neg_q <= a_neg;
                        if (i_divisor != 32'd0) begin
                            quo_q         <= a_mag;
                            rem_q         <= 32'd0;
                            dvs_q         <= b_mag;
                            dz_pend_q     <= 1'b0;
                            o_div_by_zero <= 1'b0;
                            o_busy        <= 1'b1;
                            state_q       <= StCalc;
                        end else begin
                            // Raw dividend parked in rem_q; published as the remainder in DONE.
                            quo_q     <= 32'd0;
                            rem_q     <= i_dividend;
                            dvs_q     <= 32'd0;
                            dz_pend_q <= 1'b1;
                            state_q   <= StDone;
                        end
                    end
                end
                StCalc: begin
                    rem_q <= fits ? diff[31:0] : rem_sh[31:0];
                    quo_q <= {quo_q[30:0], fits};
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    o_quotient  <= q_neg_q ? (32'd0 - quo_q) : quo_q;
                    o_remainder <= r_neg_q ? (32'd0 - rem_q) : rem_q;
                    o_busy      <= 1'b0;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (dz_pend_q) begin
                        o_quotient    <= 32'hFFFF_FFFF;
                        o_remainder   <= rem_q;
                        o_div_by_zero <= 1'b1;
                        dz_pend_q     <= 1'b0;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: signed and unsigned instances share stimulus; results are compared
// against plain-arithmetic division in a reference function.
module tb_div32_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;

    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        busy_s, done_s, dz_s, busy_u, done_u, dz_u;

    int checks = 0;
    int errors = 0;

    div32_seq #(.SIGNED(1'b1)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_dividend(dividend),
        .i_divisor(divisor), .o_quotient(quo_s), .o_remainder(rem_s), .o_busy(busy_s),
        .o_done(done_s), .o_div_by_zero(dz_s)
    );

    div32_seq #(.SIGNED(1'b0)) dut_u (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_dividend(dividend),
        .i_divisor(divisor), .o_quotient(quo_u), .o_remainder(rem_u), .o_busy(busy_u),
        .o_done(done_u), .o_div_by_zero(dz_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Truncating division on 64-bit integers; low 32 bits give the wrapped result.
    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_q_s"}, quo_s, 32'd0);
        check({tag, "_r_s"}, rem_s, 32'd0);
        check({tag, "_flags_s"}, {29'd0, busy_s, done_s, dz_s}, 32'd0);
        check({tag, "_q_u"}, quo_u, 32'd0);
        check({tag, "_r_u"}, rem_u, 32'd0);
        check({tag, "_flags_u"}, {29'd0, busy_u, done_u, dz_u}, 32'd0);
    endtask

    // One division on both instances; poke re-pulses start mid-CALC with other operands.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        logic [31:0] eq_s, er_s, eq_u, er_u;
        int n;
        int lat;
        model(1'b1, a, b, eq_s, er_s);
        model(1'b0, a, b, eq_u, er_u);
        lat = (b == 32'd0) ? 1 : 34;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check({tag, "_busy"}, {31'd0, busy_s}, {31'd0, (b != 32'd0)});
        n = 0;
        while (!done_s && n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (poke) begin
                start = (n == 5);
                if (n == 10) check({tag, "_busy_mid"}, {31'd0, busy_s}, 32'd1);
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, n, lat);
        check({tag, "_done_u"}, {31'd0, done_u}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy_s}, 32'd0);
        check({tag, "_q_s"}, quo_s, eq_s);
        check({tag, "_r_s"}, rem_s, er_s);
        check({tag, "_dz_s"}, {31'd0, dz_s}, {31'd0, (b == 32'd0)});
        check({tag, "_q_u"}, quo_u, eq_u);
        check({tag, "_r_u"}, rem_u, er_u);
        check({tag, "_dz_u"}, {31'd0, dz_u}, {31'd0, (b == 32'd0)});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {30'd0, done_s, done_u}, 32'd0);
        check({tag, "_q_hold"}, quo_s, eq_s);
    endtask

    initial begin
        int seen_done;
        logic [31:0] ra, rb;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("100_7", 32'd100, 32'd7, 1'b0);
        check("100_7_q_const", quo_s, 32'h0000_000E);
        check("100_7_r_const", rem_s, 32'h0000_0002);
        run_op("m100_7", 32'hFFFF_FF9C, 32'd7, 1'b0);
        check("m100_7_q_const", quo_s, 32'hFFFF_FFF2);
        check("m100_7_r_const", rem_s, 32'hFFFF_FFFE);
        run_op("100_m7", 32'd100, 32'hFFFF_FFF9, 1'b0);
        check("100_m7_q_const", quo_s, 32'hFFFF_FFF2);
        check("100_m7_r_const", rem_s, 32'h0000_0002);
        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_q_const", quo_s, 32'h8000_0000);
        run_op("umax_2", 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("umax_2_q_const", quo_u, 32'h7FFF_FFFF);
        check("umax_2_r_const", rem_u, 32'd1);
        run_op("5_0", 32'd5, 32'd0, 1'b0);
        check("5_0_r_const", rem_s, 32'd5);
        run_op("9_3", 32'd9, 32'd3, 1'b0);
        check("9_3_q_const", quo_s, 32'd3);
        run_op("poke", 32'd1000, 32'd13, 1'b1);

        // Asynchronous reset mid-CALC: outputs clear before the next edge, no done follows.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_s || done_u) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        run_op("after_abort", 32'd100, 32'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 16);
                2: rb = 32'd0 - $urandom_range(1, 16);
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            run_op("rand", ra, rb, (rb != 32'd0) && (i % 7 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
